// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control sequencer: opcodes,
// ALU control, ALU operand-B selects and the FSM state enumeration.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_ADDR   = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_MEM_WR = 4'd7,
        ST_WB_ALU = 4'd8,
        ST_WB_MEM = 4'd9,
        ST_BRANCH = 4'd10,
        ST_ERR    = 4'd15
    } state_e;

    localparam logic [6:0] R_TYPE      = 7'b0110011;
    localparam logic [6:0] I_TYPE      = 7'b0010011;
    localparam logic [6:0] LOAD_TYPE   = 7'b0000011;
    localparam logic [6:0] STORE_TYPE  = 7'b0100011;
    localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

    localparam logic [1:0] OTHER_OP = 2'b00;
    localparam logic [1:0] B_OP     = 2'b01;
    localparam logic [1:0] R_OP     = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    // States that hold mem_req_o high until the memory acknowledges.
    function automatic logic is_req_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// 8-bit wait counter for the memory handshake; hit_o flags the waiting
// cycle in which the count would reach LIMIT (1..255).
module mem_timeout_cnt #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign hit_o = en_i && (cnt_q == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the shared-ALU / shared-memory RV32 subset.
// Optional retired-instruction counter enabled by MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  op_i,
    input  logic        zero_i,
    input  logic        mem_ack_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [3:0]  state_o,
    output logic [31:0] retired_o
);

    state_e     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       tmo_clr, tmo_en, tmo_hit;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        op_d         = op_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_RS2;
        alu_op_o     = OTHER_OP;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        err_o        = 1'b0;

        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ir_write_o  = 1'b1;
                    pc_write_o  = 1'b1;
                    alu_src_b_o = SRC_B_FOUR;
                    state_d     = ST_DECODE;
                end else if (tmo_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                op_d        = op_i;
                alu_src_b_o = SRC_B_IMM;
                unique case (op_i)
                    R_TYPE:                state_d = ST_EXEC_R;
                    I_TYPE:                state_d = ST_EXEC_I;
                    LOAD_TYPE, STORE_TYPE: state_d = ST_ADDR;
                    BRANCH_TYPE:           state_d = ST_BRANCH;
                    default:               state_d = ST_ERR;
                endcase
            end
            ST_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = R_OP;
                state_d     = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = R_OP;
                state_d     = ST_WB_ALU;
            end
            ST_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                state_d     = (op_q == LOAD_TYPE)  ? ST_MEM_RD :
                              (op_q == STORE_TYPE) ? ST_MEM_WR : ST_ERR;
            end
            ST_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                if (mem_ack_i)    state_d = ST_WB_MEM;
                else if (tmo_hit) state_d = ST_ERR;
            end
            ST_MEM_WR: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                mem_we_o  = 1'b1;
                if (mem_ack_i)    state_d = ST_FETCH;
                else if (tmo_hit) state_d = ST_ERR;
            end
            ST_WB_ALU: begin
                reg_write_o = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = B_OP;
                pc_src_o    = 1'b1;
                pc_write_o  = zero_i;
                state_d     = ST_FETCH;
            end
            ST_ERR:  err_o   = 1'b1;
            default: state_d = ST_ERR;
        endcase
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign state_o = state_q;

    // Counter restarts whenever a request state is newly entered, including
    // the MEM_WR -> FETCH hand-over between two back-to-back accesses.
    assign tmo_en  = is_req_state(state_q) && !mem_ack_i;
    assign tmo_clr = (state_d != state_q) && is_req_state(state_d);

    mem_timeout_cnt #(
        .LIMIT (MEM_TIMEOUT)
    ) u_tmo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tmo_clr),
        .en_i  (tmo_en),
        .hit_o (tmo_hit)
    );

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;

    always_comb begin
        retire = (state_d == ST_FETCH) &&
                 ((state_q == ST_WB_ALU) || (state_q == ST_WB_MEM) ||
                  (state_q == ST_MEM_WR) || (state_q == ST_BRANCH));
        retired_d = retired_q + {31'd0, retire};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_o = retired_q;
`else
    assign retired_o = '0;
`endif

endmodule
